// File: rtl/fir_mac_sequencer.sv
// Control stage for the MAC16 FIR datapath: delay line, tap sequencing, accumulator capture and narrowing.
// Build option FIR_SAT_EN: saturate the narrowed output instead of two's-complement wrap.
module fir_mac_sequencer #(
  parameter int NTAPS   = 8,
  parameter int DW      = 16,
  parameter int ACCW    = 32,
  parameter int MAC_LAT = 3,
  parameter int SHIFT   = 15,
  localparam int AW     = $clog2(NTAPS),
  localparam int CW     = $clog2(MAC_LAT + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            coef_we,
  input  logic [AW-1:0]   coef_addr,
  input  logic [DW-1:0]   coef_data,
  output logic [DW-1:0]   mac_a,
  output logic [DW-1:0]   mac_b,
  output logic            mac_load,
  input  logic [ACCW-1:0] mac_o,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data
);

  // state | meaning
  // IDLE  | waiting for a sample, coefficient writes allowed
  // RUN   | issuing one (sample, coef) pair per cycle, k = 0..NTAPS-1
  // DRAIN | waiting for the MAC pipeline to deliver the last product
  // OUT   | holding out_data until the consumer takes it
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t state, state_nxt;

  logic [DW-1:0] dline [NTAPS];
  logic [DW-1:0] coef  [NTAPS];
  logic [AW-1:0] wptr, newest, k, k_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] mac_a_nxt, mac_b_nxt, out_data_nxt, narrowed;
  logic          mac_load_nxt, out_valid_nxt, accept, coef_wr;

  localparam logic signed [ACCW:0] RND =
    (SHIFT > 0) ? ((ACCW+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;

  logic signed [ACCW:0] acc_ext, r_sum, r_shr;

  assign acc_ext = {mac_o[ACCW-1], mac_o};
  assign r_sum   = acc_ext + RND;
  assign r_shr   = r_sum >>> SHIFT;

`ifdef FIR_SAT_EN
  localparam logic signed [ACCW:0] MAXV = {{(ACCW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] MINV = {{(ACCW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  always_comb begin
    narrowed = DW'(r_shr);
    if (r_shr > MAXV)      narrowed = DW'(MAXV);
    else if (r_shr < MINV) narrowed = DW'(MINV);
  end
`else
  assign narrowed = DW'(r_shr);
`endif

  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    cnt_nxt       = cnt;
    mac_a_nxt     = '0;
    mac_b_nxt     = '0;
    mac_load_nxt  = 1'b0;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    accept        = 1'b0;
    coef_wr       = 1'b0;
    case (state)
      IDLE: begin
        coef_wr = coef_we;
        if (in_valid) begin
          accept    = 1'b1;
          k_nxt     = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        mac_a_nxt    = dline[newest - k];
        mac_b_nxt    = coef[k];
        mac_load_nxt = (k == '0);
        k_nxt        = k + 1'b1;
        if (k == AW'(NTAPS - 1)) begin
          state_nxt = DRAIN;
          cnt_nxt   = CW'(MAC_LAT);
        end
      end
      DRAIN: begin
        // the last pair leaves RUN one cycle after the state change, hence MAC_LAT+1 cycles here
        if (cnt == '0) begin
          out_data_nxt  = narrowed;
          out_valid_nxt = 1'b1;
          state_nxt     = OUT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wptr      <= '0;
      newest    <= '0;
      k         <= '0;
      cnt       <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_load  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      cnt       <= cnt_nxt;
      mac_a     <= mac_a_nxt;
      mac_b     <= mac_b_nxt;
      mac_load  <= mac_load_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      if (coef_wr) coef[coef_addr] <= coef_data;
      if (accept) begin
        dline[wptr] <= in_data;
        newest      <= wptr;
        wptr        <= wptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: two instances (SHIFT=0 and SHIFT=14) sharing stimulus, each fed by a MAC model.
module tb_fir_mac_sequencer;
  localparam int NTAPS = 4, DW = 16, ACCW = 32, MAC_LAT = 3, SH1 = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0, coef_we = 1'b0, out_ready = 1'b0;
  logic [DW-1:0]   in_data = '0, coef_data = '0;
  logic [1:0]      coef_addr = '0;

  logic            in_ready0, mac_load0, out_valid0, in_ready1, mac_load1, out_valid1;
  logic [DW-1:0]   mac_a0, mac_b0, out_data0, mac_a1, mac_b1, out_data1;
  logic signed [ACCW-1:0] acc0 = '0, acc1 = '0;

  fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .ACCW(ACCW), .MAC_LAT(MAC_LAT), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mac_a(mac_a0), .mac_b(mac_b0), .mac_load(mac_load0), .mac_o(acc0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0));

  fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .ACCW(ACCW), .MAC_LAT(MAC_LAT), .SHIFT(SH1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mac_a(mac_a1), .mac_b(mac_b1), .mac_load(mac_load1), .mac_o(acc1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1));

  // MAC models: MAC_LAT-1 input stages, then the accumulator register
  logic signed [DW-1:0] pa0 [MAC_LAT-1], pb0 [MAC_LAT-1], pa1 [MAC_LAT-1], pb1 [MAC_LAT-1];
  logic                 pl0 [MAC_LAT-1], pl1 [MAC_LAT-1];

  always @(posedge clk) begin
    acc0 <= pl0[MAC_LAT-2] ? 32'(pa0[MAC_LAT-2]) * 32'(pb0[MAC_LAT-2])
                           : acc0 + 32'(pa0[MAC_LAT-2]) * 32'(pb0[MAC_LAT-2]);
    acc1 <= pl1[MAC_LAT-2] ? 32'(pa1[MAC_LAT-2]) * 32'(pb1[MAC_LAT-2])
                           : acc1 + 32'(pa1[MAC_LAT-2]) * 32'(pb1[MAC_LAT-2]);
    for (int i = MAC_LAT - 2; i > 0; i--) begin
      pa0[i] <= pa0[i-1]; pb0[i] <= pb0[i-1]; pl0[i] <= pl0[i-1];
      pa1[i] <= pa1[i-1]; pb1[i] <= pb1[i-1]; pl1[i] <= pl1[i-1];
    end
    pa0[0] <= mac_a0; pb0[0] <= mac_b0; pl0[0] <= mac_load0;
    pa1[0] <= mac_a1; pb1[0] <= mac_b1; pl1[0] <= mac_load1;
  end

  // reference: last NTAPS accepted samples (hist[0] newest) and the coefficient image
  logic signed [DW-1:0] hist [NTAPS];
  logic signed [DW-1:0] cf   [NTAPS];
  int errors = 0, checks = 0;

  typedef struct {
    logic signed [DW-1:0] din;
    logic signed [DW-1:0] dout;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint ref_sum();
    longint s = 0;
    for (int k = 0; k < NTAPS; k++) s += longint'(hist[k]) * longint'(cf[k]);
    return s;
  endfunction

  function automatic logic signed [DW-1:0] narrow(input longint sum, input int sh);
    logic signed [ACCW-1:0] acc;
    longint r;
    acc = sum[ACCW-1:0];
    r = longint'(acc);
    if (sh > 0) r += longint'(1) <<< (sh - 1);
    r = r >>> sh;
`ifdef FIR_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[DW-1:0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NTAPS; k++) begin
      hist[k] = '0;
      cf[k]   = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_coef(input int addr, input logic signed [DW-1:0] data);
    coef_we = 1'b1; coef_addr = 2'(addr); coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
    cf[addr] = data;
  endtask

  // accept one sample, check latency and both outputs, hold in OUT for 'hold' cycles, then hand-shake
  task automatic send(input logic signed [DW-1:0] s, input int hold, input bit run_write,
                      output logic signed [DW-1:0] got0, output logic signed [DW-1:0] got1);
    int n, lat;
    logic signed [DW-1:0] e0, e1, held;
    got0 = '0; got1 = '0;
    n = 0;
    while (!in_ready0 && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_wait", longint'(in_ready0), 1);
    in_valid = 1'b1; in_data = s;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    lat = 0;
    if (run_write) begin
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd7;
      @(negedge clk);
      coef_we = 1'b0;
      lat = 1;
    end
    while (!out_valid0 && lat < 100) begin @(negedge clk); lat++; end
    chk("latency", lat, 1 + NTAPS + MAC_LAT);
    chk("out_valid_sh14", longint'(out_valid1), 1);
    e0 = narrow(ref_sum(), 0);
    e1 = narrow(ref_sum(), SH1);
    got0 = $signed(out_data0);
    got1 = $signed(out_data1);
    chk("out_data_sh0", longint'(got0), longint'(e0));
    chk("out_data_sh14", longint'(got1), longint'(e1));
    held = got0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = ~s;
      @(negedge clk);
      chk("hold_in_ready", longint'(in_ready0), 0);
      chk("hold_out_valid", longint'(out_valid0), 1);
      chk("hold_out_data", longint'($signed(out_data0)), longint'(held));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_out_valid", longint'(out_valid0), 0);
    chk("post_hs_in_ready", longint'(in_ready0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl [5];
    logic signed [DW-1:0] g0, g1;
    tbl = '{'{16'sd1, 16'sd1}, '{16'sd2, 16'sd3}, '{16'sd3, 16'sd6},
            '{16'sd4, 16'sd10}, '{16'sd5, 16'sd14}};

    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid0), 0);
    chk("rst_mac_a", longint'(mac_a0), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", longint'(in_ready0), 1);
    chk("rel_out_data", longint'(out_data0), 0);
    chk("rel_mac_b", longint'(mac_b0), 0);
    chk("rel_mac_load", longint'(mac_load0), 0);

    // impulse coefficient set
    write_coef(0, 16'sd1); write_coef(1, 16'sd0); write_coef(2, 16'sd0); write_coef(3, 16'sd0);
    send(16'sd5, 0, 1'b0, g0, g1);
    chk("impulse", longint'(g0), 5);

    // moving sum across the wptr wrap
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'sd1);
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].din, 0, 1'b0, g0, g1);
      chk("tbl_out", longint'(g0), longint'(tbl[i].dout));
    end

    // narrowing of 2^29 at SHIFT=14
    do_reset();
    write_coef(0, 16'sd16384); write_coef(1, 16'sd16384); write_coef(2, 16'sd0); write_coef(3, 16'sd0);
    send(16'sd16384, 0, 1'b0, g0, g1);
    send(16'sd16384, 0, 1'b0, g0, g1);
`ifdef FIR_SAT_EN
    chk("narrow_2p29", longint'(g1), 32767);
`else
    chk("narrow_2p29", longint'(g1), -32768);
`endif

    // back-pressure: out_ready held low, in_valid offered and ignored
    send(16'sd7, 10, 1'b0, g0, g1);
    send(16'sd1, 0, 1'b0, g0, g1);

    // coefficient write during RUN ignored, in IDLE applied
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'sd1);
    send(16'sd3, 0, 1'b1, g0, g1);
    chk("run_write_ignored", longint'(g0), 3);
    write_coef(0, 16'sd7);
    send(16'sd2, 0, 1'b0, g0, g1);
    chk("idle_write_applied", longint'(g0), 17);

    // reset in the middle of RUN
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'sd1);
    in_valid = 1'b1; in_data = 16'sd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_mac_a", longint'(mac_a0 != '0), 1);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", longint'(out_valid0), 0);
    chk("abort_mac_a", longint'(mac_a0), 0);
    chk("abort_mac_b", longint'(mac_b0), 0);
    chk("abort_mac_load", longint'(mac_load0), 0);
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'sd1);
    send(16'sd9, 0, 1'b0, g0, g1);
    chk("after_abort", longint'(g0), 9);

    // randomized samples and coefficients against the reference
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, DW'($urandom));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) write_coef(int'($urandom_range(0, NTAPS - 1)), DW'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(DW'($urandom), int'($urandom_range(0, 2)), 1'b0, g0, g1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
